// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared digit slice, LSD first, carry held between digits.
// Latency DIGITS+1 cycles from Start to Done; Start is ignored while busy and never queued.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Invalid,
    output logic [2:0]            DigitIdx
);

    localparam int         W        = 4 * DIGITS;
    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           inv_q, inv_d;
    logic           cout_q, cout_d;
    logic           invalid_q, invalid_d;
    logic [2:0]     idx_q, idx_d;

    logic [3:0]     dig_a, dig_b, dig_s;
    logic [4:0]     raw;
    logic           carry_n;
    logic           bad_dig;
    logic [W-1:0]   work_shift;

    // Single digit slice: binary add then +6 correction above 9.
    always_comb begin
        dig_a   = a_q[3:0];
        dig_b   = b_q[3:0];
        raw     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        dig_s   = raw[3:0];
        carry_n = 1'b0;
        if (raw > 5'd9) begin
            dig_s   = raw[3:0] + 4'd6;
            carry_n = 1'b1;
        end
        bad_dig    = (dig_a > 4'd9) || (dig_b > 4'd9);
        work_shift = (work_q >> 4) | (W'(dig_s) << (W - 4));
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        inv_d     = inv_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_ADD;
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    inv_d   = 1'b0;
                    work_d  = '0;
                    idx_d   = 3'd0;
                end
            end
            S_ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = carry_n;
                work_d  = work_shift;
                inv_d   = inv_q | bad_dig;
                if (idx_q == LAST_IDX) begin
                    state_d   = S_DONE;
                    idx_d     = 3'd0;
                    sum_d     = work_shift;
                    cout_d    = carry_n;
                    invalid_d = inv_q | bad_dig;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            inv_q     <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            inv_q     <= inv_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
            idx_q     <= idx_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Invalid  = invalid_q;
    assign DigitIdx = idx_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed cases plus random operands against a decimal reference.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic           Clock;
    logic           Resetn;
    logic           Start;
    logic [W-1:0]   A, B;
    logic           Cin;
    logic           Busy, Done, Cout, Invalid;
    logic [W-1:0]   Sum;
    logic [2:0]     DigitIdx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout, prev_inv;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Busy     (Busy),
        .Done     (Done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Invalid  (Invalid),
        .DigitIdx (DigitIdx)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_bad_digit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (((v >> (4 * i)) & 'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--)
            r = r * 10 + int'((v >> (4 * i)) & 'hF);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Valid operands use plain decimal arithmetic; invalid ones follow the per-digit rule.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic inv);
        int modv = 1;
        for (int i = 0; i < DIGITS; i++) modv = modv * 10;
        inv = has_bad_digit(a) || has_bad_digit(b);
        if (!inv) begin
            int tot = bcd_to_int(a) + bcd_to_int(b) + int'(cin);
            s  = int_to_bcd(tot % modv);
            co = (tot >= modv);
        end else begin
            int c = int'(cin);
            s = '0;
            for (int i = 0; i < DIGITS; i++) begin
                int da = int'((a >> (4 * i)) & 'hF);
                int db = int'((b >> (4 * i)) & 'hF);
                int t  = da + db + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = c[0];
        end
    endtask

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(0, 3) == 0)
                r[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // One full operation; inputs are scrambled right after the Start edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string tag);
        logic [W-1:0] es;
        logic ec, ei;
        model(a, b, cin, es, ec, ei);
        A = a; B = b; Cin = cin; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        for (int j = 0; j < DIGITS; j++) begin
            @(negedge Clock);
            check_eq({tag, "_add_busy"}, 32'(Busy), 32'd1);
            check_eq({tag, "_add_done"}, 32'(Done), 32'd0);
            check_eq({tag, "_add_idx"},  32'(DigitIdx), 32'(j));
            check_eq({tag, "_add_sum_hold"}, 32'(Sum), 32'(prev_sum));
            check_eq({tag, "_add_cout_hold"}, 32'(Cout), 32'(prev_cout));
            check_eq({tag, "_add_inv_hold"}, 32'(Invalid), 32'(prev_inv));
            @(posedge Clock);
        end
        @(negedge Clock);
        check_eq({tag, "_done"},    32'(Done), 32'd1);
        check_eq({tag, "_busy_d"},  32'(Busy), 32'd1);
        check_eq({tag, "_idx_d"},   32'(DigitIdx), 32'd0);
        check_eq({tag, "_sum"},     32'(Sum), 32'(es));
        check_eq({tag, "_cout"},    32'(Cout), 32'(ec));
        check_eq({tag, "_invalid"}, 32'(Invalid), 32'(ei));
        @(posedge Clock);
        @(negedge Clock);
        check_eq({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        check_eq({tag, "_idle_done"}, 32'(Done), 32'd0);
        prev_sum = es; prev_cout = ec; prev_inv = ei;
    endtask

    task automatic held_start_test(input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] b);
        logic [W-1:0] s1, s2;
        logic c1, c2, i1, i2;
        model(a1, b, 1'b0, s1, c1, i1);
        model(a2, b, 1'b0, s2, c2, i2);
        A = a1; B = b; Cin = 1'b0; Start = 1'b1;
        @(posedge Clock);
        #1 A = a2;
        for (int j = 0; j < DIGITS; j++) begin
            @(negedge Clock);
            check_eq("held1_done_low", 32'(Done), 32'd0);
            @(posedge Clock);
        end
        @(negedge Clock);
        check_eq("held1_done", 32'(Done), 32'd1);
        check_eq("held1_sum",  32'(Sum), 32'(s1));
        @(posedge Clock);
        @(negedge Clock);
        check_eq("held_gap_busy", 32'(Busy), 32'd0);
        check_eq("held_gap_done", 32'(Done), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check_eq("held2_busy", 32'(Busy), 32'd1);
        check_eq("held2_idx",  32'(DigitIdx), 32'd0);
        Start = 1'b0;
        for (int j = 1; j < DIGITS; j++) begin
            @(posedge Clock);
            @(negedge Clock);
            check_eq("held2_no_extra_done", 32'(Done), 32'd0);
        end
        @(posedge Clock);
        @(negedge Clock);
        check_eq("held2_done", 32'(Done), 32'd1);
        check_eq("held2_sum",  32'(Sum), 32'(s2));
        check_eq("held2_cout", 32'(Cout), 32'(c2));
        @(posedge Clock);
        @(negedge Clock);
        check_eq("held2_idle", 32'(Busy), 32'd0);
        prev_sum = s2; prev_cout = c2; prev_inv = i2;
    endtask

    task automatic reset_mid_op_test;
        A = 16'h9999; B = 16'h9999; Cin = 1'b1; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_pre_idx", 32'(DigitIdx), 32'd2);
        #2 Resetn = 1'b0;
        #1;
        check_eq("rst_busy",    32'(Busy), 32'd0);
        check_eq("rst_done",    32'(Done), 32'd0);
        check_eq("rst_sum",     32'(Sum), 32'd0);
        check_eq("rst_cout",    32'(Cout), 32'd0);
        check_eq("rst_invalid", 32'(Invalid), 32'd0);
        check_eq("rst_idx",     32'(DigitIdx), 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge Clock);
            check_eq("rst_no_done", 32'(Done), 32'd0);
        end
        Resetn = 1'b1;
        prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;
        @(negedge Clock);
        check_eq("rst_after_idle", 32'(Busy), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;
        #2;
        check_eq("reset_busy",    32'(Busy), 32'd0);
        check_eq("reset_done",    32'(Done), 32'd0);
        check_eq("reset_sum",     32'(Sum), 32'd0);
        check_eq("reset_cout",    32'(Cout), 32'd0);
        check_eq("reset_invalid", 32'(Invalid), 32'd0);
        check_eq("reset_idx",     32'(DigitIdx), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        do_op(16'h1234, 16'h5678, 1'b0, "basic");
        do_op(16'h9999, 16'h0001, 1'b0, "wrap");
        do_op(16'h9999, 16'h9999, 1'b1, "max");
        do_op(16'h0000, 16'h0000, 1'b1, "cin_only");
        do_op(16'h12A4, 16'h0001, 1'b0, "bad_digit");
        do_op(16'h0005, 16'h0004, 1'b0, "after_bad");
        do_op(16'hF0F0, 16'h0F0F, 1'b1, "all_bad");

        held_start_test(16'h0123, 16'h4567, 16'h0999);

        for (int n = 0; n < 40; n++)
            do_op(rand_operand(n % 3 == 0), rand_operand(n % 5 == 0), 1'($urandom), "rand");

        reset_mid_op_test();
        do_op(16'h0456, 16'h0544, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
